arm_banked_regfile: RTL and testbench

Banked ARM register file for the armcpu core: 16 architectural registers mapped onto 31 physical registers selected by the current processor mode, with parameterised read and write port counts, optional same-cycle write-to-read bypass, and a dedicated program-counter port. It sits between decode (read addresses) and writeback (write ports), and replaces the flat single-write-port register file in the datapath.

---
 rtl/arm_banked_regfile_if.sv | 27 ++
 rtl/arm_banked_regfile.sv | 97 +++++++++
 tb/tb_arm_banked_regfile.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/arm_banked_regfile_if.sv
// rtl/arm_banked_regfile_if.sv - bus bundle between decode/writeback and the banked register file
interface arm_banked_regfile_if #(
  parameter int WORD_SIZE       = 32,
  parameter int NUM_READ_PORTS  = 3,
  parameter int NUM_WRITE_PORTS = 2
);
  logic [4:0]                           mode;
  logic                                 usr_bank;
  logic [NUM_READ_PORTS*4-1:0]          rd_addr;
  logic [NUM_READ_PORTS*WORD_SIZE-1:0]  rd_data;
  logic [NUM_WRITE_PORTS-1:0]           wr_en;
  logic [NUM_WRITE_PORTS*4-1:0]         wr_addr;
  logic [NUM_WRITE_PORTS*WORD_SIZE-1:0] wr_data;
  logic                                 pc_wr_en;
  logic [WORD_SIZE-1:0]                 pc_next;
  logic [WORD_SIZE-1:0]                 pc;

  modport master (
    output mode, usr_bank, rd_addr, wr_en, wr_addr, wr_data, pc_wr_en, pc_next,
    input  rd_data, pc
  );

  modport slave (
    input  mode, usr_bank, rd_addr, wr_en, wr_addr, wr_data, pc_wr_en, pc_next,
    output rd_data, pc
  );
endinterface

// File: rtl/arm_banked_regfile.sv
// rtl/arm_banked_regfile.sv - ARM register file: 16 architectural regs banked onto 30 physical + PC
module arm_banked_regfile #(
  parameter int          WORD_SIZE       = 32,
  parameter int          NUM_READ_PORTS  = 3,
  parameter int          NUM_WRITE_PORTS = 2,
  parameter bit          BYPASS          = 1'b1,
  parameter int unsigned PC_READ_OFFSET  = 8,
  parameter int unsigned RESET_VECTOR    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  arm_banked_regfile_if.slave   bus
);

  localparam int NPHYS = 30;

  // Physical layout: 0-7 shared, 8-12 user r8-r12, 13-17 FIQ r8-r12,
  // 18+2*bank / 19+2*bank hold r13/r14 for bank USR,FIQ,IRQ,SVC,ABT,UND.
  function automatic logic [2:0] bank_of(input logic [4:0] m, input logic ub);
    if (ub) return 3'd0;
    case (m)
      5'b10001: return 3'd1;
      5'b10010: return 3'd2;
      5'b10011: return 3'd3;
      5'b10111: return 3'd4;
      5'b11011: return 3'd5;
      default:  return 3'd0;
    endcase
  endfunction

  function automatic logic [4:0] phys_idx(input logic [3:0] a, input logic [2:0] b);
    if (a < 4'd8)       return {1'b0, a};
    else if (a < 4'd13) return (b == 3'd1) ? 5'(a) + 5'd5 : 5'(a);
    else if (a < 4'd15) return 5'd18 + 5'({b, 1'b0}) + (5'(a) - 5'd13);
    else                return 5'd0;
  endfunction

  logic [WORD_SIZE-1:0] phys_q [NPHYS];
  logic [WORD_SIZE-1:0] phys_d [NPHYS];
  logic [WORD_SIZE-1:0] pc_q;
  logic [WORD_SIZE-1:0] pc_d;

  logic [2:0]                          bank;
  logic [4:0]                          wr_idx [NUM_WRITE_PORTS];
  logic [NUM_READ_PORTS*WORD_SIZE-1:0] rd_data_c;

  always_comb begin
    bank = bank_of(bus.mode, bus.usr_bank);
    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
      wr_idx[w] = phys_idx(bus.wr_addr[w*4 +: 4], bank);
    end
  end

  // Ascending port order lets the highest-index port win both collisions and r15 vs pc_wr_en.
  always_comb begin
    phys_d = phys_q;
    pc_d   = pc_q;
    if (bus.pc_wr_en) pc_d = bus.pc_next;
    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
      if (bus.wr_en[w]) begin
        if (bus.wr_addr[w*4 +: 4] == 4'd15) pc_d = bus.wr_data[w*WORD_SIZE +: WORD_SIZE];
        else phys_d[wr_idx[w]] = bus.wr_data[w*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int k = 0; k < NUM_READ_PORTS; k++) begin
      if (bus.rd_addr[k*4 +: 4] == 4'd15) begin
        rd_data_c[k*WORD_SIZE +: WORD_SIZE] = pc_q + WORD_SIZE'(PC_READ_OFFSET);
      end else begin
        rd_data_c[k*WORD_SIZE +: WORD_SIZE] = phys_q[phys_idx(bus.rd_addr[k*4 +: 4], bank)];
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
          if (BYPASS && bus.wr_en[w] && bus.wr_addr[w*4 +: 4] != 4'd15 &&
              wr_idx[w] == phys_idx(bus.rd_addr[k*4 +: 4], bank)) begin
            rd_data_c[k*WORD_SIZE +: WORD_SIZE] = bus.wr_data[w*WORD_SIZE +: WORD_SIZE];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phys_q <= '{default: '0};
      pc_q   <= WORD_SIZE'(RESET_VECTOR);
    end else begin
      phys_q <= phys_d;
      pc_q   <= pc_d;
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.pc      = pc_q;

endmodule

// File: tb/tb_arm_banked_regfile.sv
// tb/tb_arm_banked_regfile.sv - scoreboard bench for arm_banked_regfile
module tb_arm_banked_regfile;

  localparam logic [4:0] M_USR = 5'b10000, M_SYS = 5'b11111, M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010, M_SVC = 5'b10011, M_BAD = 5'b10100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arm_banked_regfile_if #(.WORD_SIZE(32), .NUM_READ_PORTS(3), .NUM_WRITE_PORTS(2)) bus ();

  arm_banked_regfile #(
    .WORD_SIZE(32), .NUM_READ_PORTS(3), .NUM_WRITE_PORTS(2),
    .BYPASS(1'b1), .PC_READ_OFFSET(8), .RESET_VECTOR(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    bit          is_pc;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: everything queued during a cycle is compared at that cycle's falling edge.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = e.is_pc ? bus.pc : bus.rd_data[e.port*32 +: 32];
        vectors++;
        if (act !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic exp_rd(input int port, input logic [31:0] v, input string name);
    sb.push_back('{name: name, is_pc: 1'b0, port: port, exp: v});
  endtask

  task automatic exp_pc(input logic [31:0] v, input string name);
    sb.push_back('{name: name, is_pc: 1'b1, port: 0, exp: v});
  endtask

  task automatic idle();
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.pc_wr_en = 1'b0;
    bus.pc_next  = '0;
    bus.usr_bank = 1'b0;
  endtask

  task automatic wr(input int p, input logic [3:0] a, input logic [31:0] d);
    bus.wr_en[p]        = 1'b1;
    bus.wr_addr[p*4 +: 4] = a;
    bus.wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd(input int p, input logic [3:0] a);
    bus.rd_addr[p*4 +: 4] = a;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    bus.mode     = M_USR;
    bus.rd_addr  = '0;
    idle();
    wr(0, 4'd5, 32'hFFFF_FFFF);
    cyc();
    cyc();
    reset = 1'b0;
    idle();

    // Reset state: all 16 addresses in USR, three ports at a time.
    for (int a = 0; a < 16; a += 3) begin
      for (int k = 0; k < 3; k++) begin
        rd(k, 4'((a + k) % 16));
        exp_rd(k, ((a + k) % 16 == 15) ? 32'h8 : 32'h0, $sformatf("reset_r%0d", (a + k) % 16));
      end
      cyc();
    end
    exp_pc(32'h0, "reset_pc");
    cyc();

    // r13 banking
    bus.mode = M_SVC; wr(0, 4'd13, 32'hAAAA_0001); cyc();
    idle(); bus.mode = M_USR; wr(0, 4'd13, 32'h5555_0002); cyc();
    idle(); rd(0, 4'd13);
    bus.mode = M_SVC; exp_rd(0, 32'hAAAA_0001, "r13_svc"); cyc();
    bus.mode = M_USR; exp_rd(0, 32'h5555_0002, "r13_usr"); cyc();
    bus.mode = M_SYS; exp_rd(0, 32'h5555_0002, "r13_sys"); cyc();
    bus.mode = M_SVC; bus.usr_bank = 1'b1; exp_rd(0, 32'h5555_0002, "r13_svc_usrbank"); cyc();
    idle();

    // FIQ r8 banking, shared r7
    bus.mode = M_FIQ; wr(0, 4'd8, 32'h1234_5678); cyc();
    idle(); rd(0, 4'd8);
    bus.mode = M_USR; exp_rd(0, 32'h0, "r8_usr"); cyc();
    bus.mode = M_FIQ; exp_rd(0, 32'h1234_5678, "r8_fiq"); cyc();
    wr(0, 4'd7, 32'h77); cyc();
    idle(); bus.mode = M_IRQ; rd(1, 4'd7); exp_rd(1, 32'h77, "r7_irq"); cyc();

    // Bypass and write collision
    bus.mode = M_USR;
    wr(0, 4'd3, 32'hDEAD_BEEF); rd(0, 4'd3); exp_rd(0, 32'hDEAD_BEEF, "bypass_r3"); cyc();
    idle(); exp_rd(0, 32'hDEAD_BEEF, "stored_r3"); cyc();
    wr(0, 4'd3, 32'h1); wr(1, 4'd3, 32'h2); exp_rd(0, 32'h2, "collide_bypass"); cyc();
    idle(); exp_rd(0, 32'h2, "collide_stored"); cyc();

    // PC priority; r15 reads never bypass
    bus.pc_wr_en = 1'b1; bus.pc_next = 32'h100; wr(1, 4'd15, 32'h200);
    rd(2, 4'd15); exp_rd(2, 32'h8, "r15_no_bypass"); cyc();
    idle(); exp_pc(32'h200, "pc_port_wins"); exp_rd(2, 32'h208, "r15_after_port"); cyc();
    bus.pc_wr_en = 1'b1; bus.pc_next = 32'h100; cyc();
    idle(); exp_pc(32'h100, "pc_next"); exp_rd(2, 32'h108, "r15_offset"); cyc();

    // Invalid mode maps as USR; reset discards in-flight write
    bus.mode = M_BAD; wr(0, 4'd14, 32'h9); cyc();
    idle(); bus.mode = M_USR; rd(0, 4'd14); exp_rd(0, 32'h9, "r14_badmode"); cyc();
    wr(0, 4'd5, 32'h55); reset = 1'b1; cyc();
    reset = 1'b0; idle(); rd(0, 4'd5); rd(1, 4'd14);
    exp_rd(0, 32'h0, "r5_after_reset"); exp_rd(1, 32'h0, "r14_after_reset");
    exp_pc(32'h0, "pc_after_reset"); cyc();

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
